// File: rtl/alu_ctrl_skid.sv
// Purpose: decodes ALUOp/funct3/funct7[5] into the ALU result-select code and queues it in a 2-entry skid buffer.
// Latency: an op pushed in cycle N is on the outputs in cycle N+1; there is no combinational in->out path.
// Backpressure: in_ready = (count != 2) and depends on registered state only, never on out_ready.
//
// Ports:
//   clk, rst                        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready               upstream handshake; alu_op, funct3 and funct7_5 carry the op
//   out_valid/out_ready             downstream handshake; alu_sel and illegal show the head entry
//   illegal_cnt                     saturating count of accepted illegal ops
module alu_ctrl_skid #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_sel,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    // The pointer and count widths below only work for two entries.
    if (DEPTH != 2) begin : g_depth_check
        $error("alu_ctrl_skid: DEPTH must be 2");
    end

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef struct packed {
        logic [3:0] sel;
        logic       illegal;
    } entry_t;

    entry_t     dec_dat;
    entry_t     mem [0:1];
    entry_t     head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    // Decode. Unsupported combinations still issue ADD so the datapath sees
    // a harmless operation; the illegal flag tells the consumer to discard it.
    always_comb begin
        dec_dat.sel     = SEL_ADD;
        dec_dat.illegal = 1'b0;
        case (alu_op)
            2'b00: dec_dat.sel = SEL_ADD;
            2'b01: dec_dat.sel = SEL_SUB;
            2'b10: begin
                case ({funct3, funct7_5})
                    4'b0000:          dec_dat.sel = SEL_ADD;
                    4'b0001:          dec_dat.sel = SEL_SUB;
                    4'b1110, 4'b1111: dec_dat.sel = SEL_AND;
                    4'b1100, 4'b1101: dec_dat.sel = SEL_OR;
                    default:          dec_dat.illegal = 1'b1;
                endcase
            end
            default: dec_dat.illegal = 1'b1;
        endcase
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head      = mem[rd_ptr];
    assign alu_sel   = head.sel;
    assign illegal   = head.illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= dec_dat;
        end
    end

    // Simultaneous push and pop leaves count unchanged while both pointers
    // advance; 1-bit pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (push && dec_dat.illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_skid.sv
// Directed bench for alu_ctrl_skid: decode table plus multi-cycle buffer sequences.
// A second instance with CNT_W=2 shares all inputs to exercise counter saturation.
module tb_alu_ctrl_skid;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_sel;
    logic       illegal;
    logic [7:0] illegal_cnt;

    logic       in_ready2;
    logic       out_valid2;
    logic [3:0] alu_sel2;
    logic       illegal2;
    logic [1:0] illegal_cnt2;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_ctrl_skid #(.CNT_W(8), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
        .out_valid(out_valid), .out_ready(out_ready), .alu_sel(alu_sel),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    alu_ctrl_skid #(.CNT_W(2), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
        .out_valid(out_valid2), .out_ready(out_ready), .alu_sel(alu_sel2),
        .illegal(illegal2), .illegal_cnt(illegal_cnt2)
    );

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] sel;
        logic       ill;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3, input logic f7);
        in_valid = v;
        alu_op   = op;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    task automatic chk_cnt(input string name);
        int sat;
        sat = (exp_cnt > 3) ? 3 : exp_cnt;
        chk({name, "_cnt8"}, 32'(illegal_cnt), 32'(exp_cnt));
        chk({name, "_cnt2"}, 32'(illegal_cnt2), 32'(sat));
    endtask

    initial begin
        vecs[0] = '{2'b00, 3'b101, 1'b1, 4'b0010, 1'b0};
        vecs[1] = '{2'b01, 3'b011, 1'b0, 4'b0110, 1'b0};
        vecs[2] = '{2'b10, 3'b000, 1'b0, 4'b0010, 1'b0};
        vecs[3] = '{2'b10, 3'b000, 1'b1, 4'b0110, 1'b0};
        vecs[4] = '{2'b10, 3'b111, 1'b0, 4'b0000, 1'b0};
        vecs[5] = '{2'b10, 3'b111, 1'b1, 4'b0000, 1'b0};
        vecs[6] = '{2'b10, 3'b110, 1'b1, 4'b0001, 1'b0};
        vecs[7] = '{2'b10, 3'b001, 1'b0, 4'b0010, 1'b1};
        vecs[8] = '{2'b11, 3'b000, 1'b0, 4'b0010, 1'b1};
        vecs[9] = '{2'b10, 3'b010, 1'b1, 4'b0010, 1'b1};

        // Reset and idle
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 3'b000, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_alu_sel", 32'(alu_sel), 32'h0);
            chk("rst_illegal", 32'(illegal), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk_cnt("rst");
            tick();
        end

        // Decode table: push one op into the empty buffer, see it next cycle, then it drains
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f7);
            tick();
            drive(1'b0, 2'b00, 3'b000, 1'b0);
            if (vecs[i].ill) exp_cnt++;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_alu_sel", i), 32'(alu_sel), 32'(vecs[i].sel));
            chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
            chk($sformatf("vec%0d_sel_w2", i), 32'(alu_sel2), 32'(vecs[i].sel));
            chk_cnt($sformatf("vec%0d", i));
            tick();
            chk($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // Fill with AND then OR while stalled; a third op must be refused
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 3'b111, 1'b0);
        tick();
        chk("full_after1_in_ready", 32'(in_ready), 32'd1);
        chk("full_after1_sel", 32'(alu_sel), 32'h0);
        drive(1'b1, 2'b10, 3'b110, 1'b0);
        tick();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_sel", 32'(alu_sel), 32'h0);
        drive(1'b1, 2'b00, 3'b000, 1'b0);
        tick();
        chk("full_refuse_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_stable", 32'(alu_sel), 32'h0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 2'b00, 3'b000, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("drain1_sel", 32'(alu_sel), 32'h1);
        chk("drain1_out_valid", 32'(out_valid), 32'd1);
        chk("drain1_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("drain2_empty", 32'(out_valid), 32'd0);

        // count=1, then simultaneous push+pop for 4 cycles
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 3'b000, 1'b0);
        tick();
        chk("pp_head0", 32'(alu_sel), 32'h2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp_sel;
            exp_sel = (i % 2 == 0) ? 4'b0110 : 4'b0010;
            drive(1'b1, (i % 2 == 0) ? 2'b01 : 2'b00, 3'b000, 1'b0);
            tick();
            chk($sformatf("pp%0d_sel", i), 32'(alu_sel), 32'(exp_sel));
            chk($sformatf("pp%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("pp%0d_in_ready", i), 32'(in_ready), 32'd1);
        end
        drive(1'b0, 2'b00, 3'b000, 1'b0);
        tick();
        chk("pp_drained", 32'(out_valid), 32'd0);

        // Two illegal ops queued, then drained in order
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 3'b000, 1'b0);
        tick();
        drive(1'b1, 2'b10, 3'b001, 1'b0);
        tick();
        drive(1'b0, 2'b00, 3'b000, 1'b0);
        exp_cnt += 2;
        chk("ill_full", 32'(in_ready), 32'd0);
        chk("ill_head_sel", 32'(alu_sel), 32'h2);
        chk("ill_head_flag", 32'(illegal), 32'd1);
        chk_cnt("ill");
        out_ready = 1'b1;
        tick();
        chk("ill_second_valid", 32'(out_valid), 32'd1);
        chk("ill_second_sel", 32'(alu_sel), 32'h2);
        chk("ill_second_flag", 32'(illegal), 32'd1);
        tick();
        chk("ill_drained", 32'(out_valid), 32'd0);
        chk_cnt("ill_after");

        // Reset while full, with a push and pop offered in the reset cycle
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 3'b111, 1'b0);
        tick();
        drive(1'b1, 2'b10, 3'b110, 1'b0);
        tick();
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 2'b11, 3'b000, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 2'b00, 3'b000, 1'b0);
        exp_cnt = 0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_sel", 32'(alu_sel), 32'h0);
        chk("midrst_illegal", 32'(illegal), 32'd0);
        chk_cnt("midrst");
        tick();
        chk("midrst_still_empty", 32'(out_valid), 32'd0);
        chk_cnt("midrst_after");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
